// File: rtl/jk_output_monitor.sv
// Monitor for the JK-flop FSM output: edge pulses, toggle count, run length,
// stuck alarm and overlapping "1011" detector. Optional macro: JK_MONITOR_STICKY_STUCK_EN.
module jk_output_monitor #(
  parameter int CNT_W       = 8,
  parameter int STUCK_LIMIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             stuck_flag,
  output logic             seq_det
);

  typedef enum logic [1:0] {S_IDLE, S_1, S_10, S_101} seq_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STUCK_LIMIT);

  seq_t state, state_nxt;
  logic y_q;
  logic primed;
  logic edge_seen;
  logic seq_hit;
  logic stuck_cmp;

  assign edge_seen = primed & (y_in ^ y_q);
  assign stuck_cmp = (run_len >= LIMIT);

  always_comb begin
    state_nxt = state;
    seq_hit   = 1'b0;
    if (clr) begin
      state_nxt = S_IDLE;
    end else if (primed) begin
      case (state)
        S_IDLE: state_nxt = y_in ? S_1 : S_IDLE;
        S_1:    state_nxt = y_in ? S_1 : S_10;
        S_10:   state_nxt = y_in ? S_101 : S_IDLE;
        S_101: begin
          // Overlap: the trailing 1 of "1011" starts the next match.
          state_nxt = y_in ? S_1 : S_10;
          seq_hit   = y_in;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q        <= 1'b0;
      primed     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      run_len    <= '0;
      toggle_cnt <= '0;
      seq_det    <= 1'b0;
    end else begin
      // y_q tracks y_in even under clr so no false edge appears afterwards.
      y_q <= y_in;
      if (clr) begin
        rise_pulse <= 1'b0;
        fall_pulse <= 1'b0;
        toggle_cnt <= '0;
        seq_det    <= 1'b0;
        run_len    <= primed ? CNT_W'(1) : '0;
      end else if (!primed) begin
        primed     <= 1'b1;
        run_len    <= CNT_W'(1);
        rise_pulse <= 1'b0;
        fall_pulse <= 1'b0;
        seq_det    <= 1'b0;
      end else begin
        rise_pulse <= y_in & ~y_q;
        fall_pulse <= ~y_in & y_q;
        seq_det    <= seq_hit;
        if (edge_seen) begin
          run_len <= CNT_W'(1);
          if (toggle_cnt != CNT_MAX) toggle_cnt <= toggle_cnt + 1'b1;
        end else if (run_len != CNT_MAX) begin
          run_len <= run_len + 1'b1;
        end
      end
    end
  end

`ifdef JK_MONITOR_STICKY_STUCK_EN
  logic stuck_q;

  always_ff @(posedge clk) begin
    if (reset || clr)   stuck_q <= 1'b0;
    else if (stuck_cmp) stuck_q <= 1'b1;
  end

  assign stuck_flag = stuck_q | stuck_cmp;
`else
  assign stuck_flag = stuck_cmp;
`endif

endmodule

// File: tb/tb_jk_output_monitor.sv
// Directed bench for jk_output_monitor: main instance (CNT_W=8, limit 16) plus a
// narrow instance (CNT_W=2, limit 3) for saturation; honours JK_MONITOR_STICKY_STUCK_EN.
module tb_jk_output_monitor;

  logic clk = 1'b0;
  logic reset, y_in, clr;
  logic y_b, clr_b;
  logic rise_pulse, fall_pulse, stuck_flag, seq_det;
  logic [7:0] run_len, toggle_cnt;
  logic rise_b, fall_b, stuck_b, seq_b;
  logic [1:0] run_b, tog_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  jk_output_monitor #(.CNT_W(8), .STUCK_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .clr(clr),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .run_len(run_len),
    .toggle_cnt(toggle_cnt), .stuck_flag(stuck_flag), .seq_det(seq_det)
  );

  jk_output_monitor #(.CNT_W(2), .STUCK_LIMIT(3)) dut_b (
    .clk(clk), .reset(reset), .y_in(y_b), .clr(clr_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .run_len(run_b),
    .toggle_cnt(tog_b), .stuck_flag(stuck_b), .seq_det(seq_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic yv);
    @(negedge clk);
    reset = r;
    clr   = c;
    y_in  = yv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input int rp, input int fp,
                          input int rl, input int tc, input int sf, input int sd);
    chk({tag, ".rise"},   int'(rise_pulse), rp);
    chk({tag, ".fall"},   int'(fall_pulse), fp);
    chk({tag, ".run"},    int'(run_len), rl);
    chk({tag, ".tog"},    int'(toggle_cnt), tc);
    chk({tag, ".stuck"},  int'(stuck_flag), sf);
    chk({tag, ".seq"},    int'(seq_det), sd);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; y_in = 1'b1; y_b = 1'b0; clr_b = 1'b0;

    // reset, then priming with y_in=1: no rise pulse
    drive(1, 0, 1);
    chk_main("reset", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1);
    chk_main("prime", 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1);
    chk_main("hold1a", 0, 0, 2, 0, 0, 0);
    drive(0, 0, 1);
    chk_main("hold1b", 0, 0, 3, 0, 0, 0);

    // edge pulses
    drive(0, 0, 0);
    chk_main("fall1", 0, 1, 1, 1, 0, 0);
    drive(0, 0, 0);
    chk_main("low2", 0, 0, 2, 1, 0, 0);
    drive(0, 0, 1);
    chk_main("rise1", 1, 0, 1, 2, 0, 0);
    drive(0, 0, 1);
    chk_main("high2", 0, 0, 2, 2, 0, 0);
    drive(0, 0, 0);
    chk_main("fall2", 0, 1, 1, 3, 0, 0);

    // stuck alarm: 20 zero samples total
    for (int i = 2; i <= 20; i++) begin
      drive(0, 0, 0);
      chk("stuck.run", int'(run_len), i);
      chk("stuck.flag", int'(stuck_flag), (i >= 16) ? 1 : 0);
    end
    drive(0, 0, 1);
    chk("unstuck.run", int'(run_len), 1);
    chk("unstuck.rise", int'(rise_pulse), 1);
`ifdef JK_MONITOR_STICKY_STUCK_EN
    chk("unstuck.flag", int'(stuck_flag), 1);
    drive(0, 0, 0);
    chk("sticky.hold", int'(stuck_flag), 1);
    drive(0, 0, 1);
    chk("sticky.hold2", int'(stuck_flag), 1);
`else
    chk("unstuck.flag", int'(stuck_flag), 0);
`endif
    drive(0, 1, 1);
    chk_main("clr", 0, 0, 1, 0, 0, 0);

    // sequence 1,0,1,1,0,1,1 (overlapping detection)
    drive(0, 0, 1); chk("seqA1", int'(seq_det), 0);
    drive(0, 0, 0); chk("seqA2", int'(seq_det), 0);
    drive(0, 0, 1); chk("seqA3", int'(seq_det), 0);
    drive(0, 0, 1); chk("seqA4", int'(seq_det), 1);
    drive(0, 0, 0); chk("seqA5", int'(seq_det), 0);
    drive(0, 0, 1); chk("seqA6", int'(seq_det), 0);
    drive(0, 0, 1); chk("seqA7", int'(seq_det), 1);
    // sequence 1,1,0,1,0: no detection
    drive(0, 0, 1); chk("seqB1", int'(seq_det), 0);
    drive(0, 0, 1); chk("seqB2", int'(seq_det), 0);
    drive(0, 0, 0); chk("seqB3", int'(seq_det), 0);
    drive(0, 0, 1); chk("seqB4", int'(seq_det), 0);
    drive(0, 0, 0); chk("seqB5", int'(seq_det), 0);

    // reach S_101, then reset on the sample that would complete "1011"
    drive(0, 0, 1); chk("pre101", int'(seq_det), 0);
    drive(1, 1, 1);
    chk_main("midreset", 0, 0, 0, 0, 0, 0);

    // reprime, then clr during a 0->1 sample
    drive(0, 0, 0); chk_main("reprime", 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0); chk("low.run", int'(run_len), 2);
    drive(0, 1, 1);
    chk_main("clredge", 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1);
    chk_main("postclr", 0, 0, 2, 0, 0, 0);
    drive(0, 0, 0);
    chk_main("postclr.fall", 0, 1, 1, 1, 0, 0);

    // narrow instance: run_len saturated at 3, then toggle every cycle
    chk("b.runsat", int'(run_b), 3);
    chk("b.stuck", int'(stuck_b), 1);
    for (int i = 1; i <= 6; i++) begin
      y_b = (i % 2 == 1);
      drive(0, 0, 0);
      chk("b.tog", int'(tog_b), (i < 3) ? i : 3);
      chk("b.run", int'(run_b), 1);
      chk("b.rise", int'(rise_b), (i % 2 == 1) ? 1 : 0);
      chk("b.fall", int'(fall_b), (i % 2 == 0) ? 1 : 0);
    end
`ifdef JK_MONITOR_STICKY_STUCK_EN
    chk("b.stuck2", int'(stuck_b), 1);
`else
    chk("b.stuck2", int'(stuck_b), 0);
`endif
    y_b = 1'b1; clr_b = 1'b1;
    drive(0, 0, 0);
    chk("b.clr.tog", int'(tog_b), 0);
    chk("b.clr.rise", int'(rise_b), 0);
    chk("b.clr.run", int'(run_b), 1);
    chk("b.clr.stuck", int'(stuck_b), 0);
    clr_b = 1'b0;
    drive(0, 0, 0);
    chk("b.after.rise", int'(rise_b), 0);
    chk("b.after.run", int'(run_b), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
